down_counter_bank: RTL and testbench

//  Bank of N_CH independent loadable down-counters, each decremented by STEP per enable.

---
 rtl/dcb_pkg.sv | 36 +++
 rtl/dcb_channel.sv | 93 +++++++++
 rtl/down_counter_bank.sv | 99 +++++++++
 tb/tb_down_counter_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcb_pkg.sv
// ============================================================================
//  Module      : dcb_pkg
//  Description : Shared definitions for the down-counter bank: channel-index
//                width computation, reset constants and parameter-range check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcb_pkg;

    // Reset values of the registered output flags.
    localparam logic C_RST_BOUT = 1'b0;
    localparam logic C_RST_V    = 1'b0;
    localparam logic C_RST_Z    = 1'b1;

    // Ceiling log2, evaluated at elaboration time. Returns at least 1 so a
    // channel-select port always has a legal width.
    function automatic int dcb_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // STEP must be a non-zero value representable in B_W bits.
    function automatic bit dcb_step_ok(input int bw, input int step);
        return (step >= 1) && (step <= ((1 << bw) - 1));
    endfunction

endpackage : dcb_pkg

`default_nettype wire

// File: rtl/dcb_channel.sv
// ============================================================================
//  Module      : dcb_channel
//  Description : One loadable down-counter with registered borrow and
//                signed-overflow pulses. Priority load > decrement > hold.
//                Build option DCB_SATURATE_EN: a borrowing decrement clamps
//                the count at 0 and suppresses the overflow pulse.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                load_i          load load_val_i this cycle
//                load_val_i      value to load
//                dec_i           decrement by STEP this cycle
//                cnt_o           current count
//                borrow_o        1-cycle borrow pulse
//                ovf_o           1-cycle signed-overflow pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcb_channel
    import dcb_pkg::*;
#(
    parameter int B_W  = 4,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [B_W-1:0] load_val_i,
    input  logic           dec_i,
    output logic [B_W-1:0] cnt_o,
    output logic           borrow_o,
    output logic           ovf_o
);

    localparam logic [B_W:0] C_STEP_EXT = (B_W + 1)'(STEP);

    logic [B_W-1:0] cnt_q, cnt_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;

    logic [B_W:0]   w_diff;
    logic           w_borrow;
    logic           w_ovf;

    // One extra bit on the subtraction: its MSB is the unsigned borrow.
    assign w_diff   = {1'b0, cnt_q} - C_STEP_EXT;
    assign w_borrow = w_diff[B_W];
    // Signed overflow of a - b: operands differ in sign and the result sign
    // differs from the minuend.
    assign w_ovf    = (cnt_q[B_W-1] ^ C_STEP_EXT[B_W-1]) &
                      (cnt_q[B_W-1] ^ w_diff[B_W-1]);

    always_comb begin
        cnt_d    = cnt_q;
        borrow_d = 1'b0;
        ovf_d    = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
`ifdef DCB_SATURATE_EN
            if (w_borrow) begin
                cnt_d    = '0;
                borrow_d = 1'b1;
            end else begin
                cnt_d = w_diff[B_W-1:0];
                ovf_d = w_ovf;
            end
`else
            cnt_d    = w_diff[B_W-1:0];
            borrow_d = w_borrow;
            ovf_d    = w_ovf;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;

endmodule : dcb_channel

`default_nettype wire

// File: rtl/down_counter_bank.sv
// ============================================================================
//  Module      : down_counter_bank
//  Description : Bank of N_CH loadable down-counters, each decremented by STEP
//                per enable, with one registered read port selected by rd_sel.
//                Build option DCB_SATURATE_EN: saturate at 0 instead of wrap.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                load_en    load load_val into channel load_ch
//                load_ch    channel to load (ignored if >= N_CH)
//                load_val   load value
//                dec_en     per-channel decrement enables
//                rd_sel     channel routed to outputs (>= N_CH reads ch 0)
//                Y          registered count of selected channel
//                Bout       registered borrow pulse of selected channel
//                V          registered signed-overflow pulse
//                Z          registered zero flag of selected channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_bank
    import dcb_pkg::*;
#(
    parameter  int B_W  = 4,
    parameter  int N_CH = 2,
    parameter  int STEP = 1,
    localparam int CHW  = dcb_clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [CHW-1:0]  load_ch,
    input  logic [B_W-1:0]  load_val,
    input  logic [N_CH-1:0] dec_en,
    input  logic [CHW-1:0]  rd_sel,
    output logic [B_W-1:0]  Y,
    output logic            Bout,
    output logic            V,
    output logic            Z
);

    generate
        if (!dcb_step_ok(B_W, STEP) || (B_W < 2) || (N_CH < 2)) begin : g_bad_param
            $error("down_counter_bank: illegal B_W/N_CH/STEP combination");
        end
    endgenerate

    logic [B_W-1:0]  w_cnt [N_CH];
    logic [N_CH-1:0] w_borrow;
    logic [N_CH-1:0] w_ovf;
    logic [CHW-1:0]  w_sel;

    logic [B_W-1:0]  y_q;
    logic            bout_q;
    logic            v_q;
    logic            z_q;

    // An out-of-range load_ch matches no channel, so the load is dropped.
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            dcb_channel #(
                .B_W  (B_W),
                .STEP (STEP)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .load_i     (load_en && (load_ch == CHW'(i))),
                .load_val_i (load_val),
                .dec_i      (dec_en[i]),
                .cnt_o      (w_cnt[i]),
                .borrow_o   (w_borrow[i]),
                .ovf_o      (w_ovf[i])
            );
        end
    endgenerate

    assign w_sel = (int'(rd_sel) < N_CH) ? rd_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= '0;
            bout_q <= C_RST_BOUT;
            v_q    <= C_RST_V;
            z_q    <= C_RST_Z;
        end else begin
            y_q    <= w_cnt[w_sel];
            bout_q <= w_borrow[w_sel];
            v_q    <= w_ovf[w_sel];
            z_q    <= (w_cnt[w_sel] == '0);
        end
    end

    assign Y    = y_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule : down_counter_bank

`default_nettype wire

// File: tb/tb_down_counter_bank.sv
// ============================================================================
//  Module      : tb_down_counter_bank
//  Description : Scoreboard bench for down_counter_bank. Each driven cycle
//                pushes the output expected one edge later, computed from an
//                integer model of the counting rules; a monitor pops and
//                compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter_bank;

    localparam int B_W  = 4;
    localparam int N_CH = 3;
    localparam int STEP = 1;
    localparam int CHW  = 2;

    typedef struct {
        int y;
        bit b;
        bit v;
        bit z;
        int ph;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [CHW-1:0]  load_ch;
    logic [B_W-1:0]  load_val;
    logic [N_CH-1:0] dec_en;
    logic [CHW-1:0]  rd_sel;
    logic [B_W-1:0]  Y;
    logic            Bout;
    logic            V;
    logic            Z;

    exp_t sbq[$];
    int   m_cnt [N_CH];
    bit   m_b   [N_CH];
    bit   m_v   [N_CH];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;

    always #5 clk = ~clk;

    down_counter_bank #(
        .B_W  (B_W),
        .N_CH (N_CH),
        .STEP (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .load_ch  (load_ch),
        .load_val (load_val),
        .dec_en   (dec_en),
        .rd_sel   (rd_sel),
        .Y        (Y),
        .Bout     (Bout),
        .V        (V),
        .Z        (Z)
    );

    // Drive one cycle of stimulus, record the output the next edge must
    // produce, then advance the model state by that edge.
    task automatic step(input bit r, input bit le, input int lch, input int lval,
                        input int dmask, input int rs);
        exp_t e;
        int   s, half, full, sc, ss, ex;
        bit   ov;
        @(negedge clk);
        rst      = r;
        load_en  = le;
        load_ch  = lch[CHW-1:0];
        load_val = lval[B_W-1:0];
        dec_en   = dmask[N_CH-1:0];
        rd_sel   = rs[CHW-1:0];
        half = 1 << (B_W - 1);
        full = 1 << B_W;
        if (r) begin
            e = '{0, 1'b0, 1'b0, 1'b1, phase};
            for (int c = 0; c < N_CH; c++) begin
                m_cnt[c] = 0;
                m_b[c]   = 0;
                m_v[c]   = 0;
            end
        end else begin
            s = (rs < N_CH) ? rs : 0;
            e = '{m_cnt[s], m_b[s], m_v[s], (m_cnt[s] == 0), phase};
            for (int c = 0; c < N_CH; c++) begin
                if (le && lch == c) begin
                    m_cnt[c] = lval;
                    m_b[c]   = 0;
                    m_v[c]   = 0;
                end else if (dmask[c]) begin
                    sc = (m_cnt[c] >= half) ? m_cnt[c] - full : m_cnt[c];
                    ss = (STEP >= half) ? STEP - full : STEP;
                    ex = sc - ss;
                    ov = (ex < -half) || (ex > half - 1);
                    if (m_cnt[c] < STEP) begin
                        m_b[c] = 1;
`ifdef DCB_SATURATE_EN
                        m_cnt[c] = 0;
                        m_v[c]   = 0;
`else
                        m_cnt[c] = m_cnt[c] - STEP + full;
                        m_v[c]   = ov;
`endif
                    end else begin
                        m_b[c]   = 0;
                        m_cnt[c] = m_cnt[c] - STEP;
                        m_v[c]   = ov;
                    end
                end else begin
                    m_b[c] = 0;
                    m_v[c] = 0;
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int rs, input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, rs);
    endtask

    // Monitor: one output word per rising edge, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (Y !== e.y[B_W-1:0] || Bout !== e.b || V !== e.v || Z !== e.z) begin
                    errors++;
                    $display("FAIL out phase %0d: got Y=%0d Bout=%0b V=%0b Z=%0b, need Y=%0d Bout=%0b V=%0b Z=%0b",
                             e.ph, Y, Bout, V, Z, e.y, e.b, e.v, e.z);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; load_ch = '0; load_val = '0;
        dec_en = '0; rd_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0; m_b[c] = 0; m_v[c] = 0;
        end

        // Reset, then reset held against a load and decrements.
        phase = 1;
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 9, 3'b111, 0);
        idle(0, 2);

        // Load ch1=3 and count through zero into the wrap.
        phase = 2;
        step(0, 1, 1, 3, 0, 1);
        repeat (4) step(0, 0, 0, 0, 3'b010, 1);
        idle(1, 2);

        // Signed overflow from -8, then borrow from 0.
        phase = 3;
        step(0, 1, 0, 8, 0, 0);
        step(0, 0, 0, 0, 3'b001, 0);
        idle(0, 2);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3'b001, 0);
        idle(0, 2);

        // Load beats decrement on the same channel; the other still counts.
        phase = 4;
        step(0, 1, 1, 9, 0, 0);
        step(0, 1, 0, 5, 3'b011, 0);
        idle(0, 1);
        idle(1, 2);

        // Out-of-range load channel and read select.
        phase = 5;
        step(0, 1, 3, 12, 0, 3);
        step(0, 1, 2, 7, 0, 3);
        idle(2, 2);
        idle(3, 2);

        // Reset in the middle of a count, then rd_sel flip with no decrement.
        phase = 6;
        step(0, 1, 0, 6, 0, 0);
        repeat (3) step(0, 0, 0, 0, 3'b001, 0);
        step(1, 0, 0, 0, 3'b001, 0);
        idle(0, 2);
        step(0, 1, 1, 4, 0, 0);
        idle(0, 2);
        idle(1, 2);

        // Randomized traffic.
        phase = 7;
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end
        idle(0, 1);

        // Drain: every expected entry must be consumed within a few edges.
        for (int k = 0; k < 8 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, need 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_down_counter_bank

`default_nettype wire
